// File: rtl/syncn_decoder_mch_if.sv
// Link-control bus between the multi-channel SYNC~ decoder and the TX link FSM.
// Error-counter signals exist only when SYNCN_ERR_CNT_EN is defined.
interface syncn_decoder_mch_if #(
  parameter int NUM_CH    = 2,
  parameter int ERR_CNT_W = 8
);
  logic                        i_frame_tick;
  logic [NUM_CH-1:0]           i_sync_n;
  logic [NUM_CH-1:0]           o_sync_request;
  logic                        o_sync_req_any;
  logic [NUM_CH-1:0]           o_err_report;
  logic [NUM_CH-1:0]           o_sync_deassert;
`ifdef SYNCN_ERR_CNT_EN
  logic [NUM_CH*ERR_CNT_W-1:0] o_err_cnt;
  logic                        i_err_cnt_clr;
`endif

  modport master (
`ifdef SYNCN_ERR_CNT_EN
    output i_err_cnt_clr,
    input  o_err_cnt,
`endif
    output i_frame_tick,
    output i_sync_n,
    input  o_sync_request,
    input  o_sync_req_any,
    input  o_err_report,
    input  o_sync_deassert
  );

  modport slave (
`ifdef SYNCN_ERR_CNT_EN
    input  i_err_cnt_clr,
    output o_err_cnt,
`endif
    input  i_frame_tick,
    input  i_sync_n,
    output o_sync_request,
    output o_sync_req_any,
    output o_err_report,
    output o_sync_deassert
  );
endinterface

// File: rtl/syncn_decoder_mch.sv
// Multi-channel JESD204B SYNC~ decoder: synchronise, deglitch and classify low pulses by frame length.
// Optional per-channel saturating error counters are enabled by defining SYNCN_ERR_CNT_EN.
module syncn_decoder_mch #(
  parameter int NUM_CH          = 2,
  parameter int SYNC_REQ_FRAMES = 5,
  parameter int ERR_MIN_FRAMES  = 1,
  parameter int ERR_MAX_FRAMES  = 2,
  parameter int DEGLITCH        = 2,
  parameter int ERR_CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  syncn_decoder_mch_if.slave   bus
);

  localparam int FC_W = $clog2(SYNC_REQ_FRAMES + 1);
  localparam int DG_W = $clog2(DEGLITCH + 1);

  localparam logic [FC_W-1:0] FC_MAX     = FC_W'(SYNC_REQ_FRAMES);
  localparam logic [FC_W-1:0] FC_ERR_MIN = FC_W'(ERR_MIN_FRAMES);
  localparam logic [FC_W-1:0] FC_ERR_MAX = FC_W'(ERR_MAX_FRAMES);
  localparam logic [DG_W-1:0] DG_LAST    = DG_W'(DEGLITCH - 1);

  typedef enum logic [1:0] {
    ST_HIGH = 2'd0,
    ST_LOW  = 2'd1,
    ST_REQ  = 2'd2
  } state_e;

  logic [NUM_CH-1:0] sync1_q, sync2_q;
  logic [NUM_CH-1:0] filt_q, filt_d;
  logic [DG_W-1:0]   dg_cnt_q [NUM_CH];
  logic [DG_W-1:0]   dg_cnt_d [NUM_CH];
  logic [FC_W-1:0]   frm_cnt_q [NUM_CH];
  logic [FC_W-1:0]   frm_cnt_d [NUM_CH];
  state_e            state_q [NUM_CH];
  state_e            state_d [NUM_CH];
  logic [NUM_CH-1:0] req_q, req_d;
  logic [NUM_CH-1:0] err_q, err_d;
  logic [NUM_CH-1:0] deas_q, deas_d;
  logic              req_any_q, req_any_d;

  // Filtered level flips only after DEGLITCH consecutive synchronised samples disagree with it.
  always_comb begin
    filt_d = filt_q;
    for (int c = 0; c < NUM_CH; c++) begin
      dg_cnt_d[c] = {DG_W{1'b0}};
      if (sync2_q[c] != filt_q[c]) begin
        if (dg_cnt_q[c] == DG_LAST) begin
          filt_d[c]   = sync2_q[c];
          dg_cnt_d[c] = {DG_W{1'b0}};
        end else begin
          dg_cnt_d[c] = dg_cnt_q[c] + DG_W'(1);
        end
      end else begin
        dg_cnt_d[c] = {DG_W{1'b0}};
      end
    end
  end

  // Per-channel pulse classifier; a rise in the same cycle as a tick is judged on the pre-tick count.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      state_d[c]   = state_q[c];
      frm_cnt_d[c] = frm_cnt_q[c];
      req_d[c]     = req_q[c];
      err_d[c]     = 1'b0;
      deas_d[c]    = 1'b0;
      case (state_q[c])
        ST_HIGH: begin
          req_d[c] = 1'b0;
          if (!filt_q[c]) begin
            state_d[c]   = ST_LOW;
            frm_cnt_d[c] = {FC_W{1'b0}};
          end else begin
            state_d[c]   = ST_HIGH;
          end
        end
        ST_LOW: begin
          req_d[c] = 1'b0;
          if (filt_q[c]) begin
            state_d[c] = ST_HIGH;
            err_d[c]   = (frm_cnt_q[c] >= FC_ERR_MIN) && (frm_cnt_q[c] <= FC_ERR_MAX);
          end else if (bus.i_frame_tick) begin
            if (frm_cnt_q[c] == FC_MAX) begin
              frm_cnt_d[c] = frm_cnt_q[c];
            end else begin
              frm_cnt_d[c] = frm_cnt_q[c] + FC_W'(1);
            end
            if ((frm_cnt_q[c] + FC_W'(1)) == FC_MAX) begin
              state_d[c] = ST_REQ;
              req_d[c]   = 1'b1;
            end else begin
              state_d[c] = ST_LOW;
            end
          end else begin
            state_d[c] = ST_LOW;
          end
        end
        ST_REQ: begin
          if (filt_q[c]) begin
            state_d[c] = ST_HIGH;
            req_d[c]   = 1'b0;
            deas_d[c]  = 1'b1;
          end else begin
            state_d[c] = ST_REQ;
            req_d[c]   = 1'b1;
          end
        end
        default: begin
          state_d[c]   = ST_HIGH;
          frm_cnt_d[c] = {FC_W{1'b0}};
          req_d[c]     = 1'b0;
        end
      endcase
    end
    req_any_d = |req_d;
  end

  // Synchroniser, deglitch, classifier state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= {NUM_CH{1'b1}};
      sync2_q   <= {NUM_CH{1'b1}};
      filt_q    <= {NUM_CH{1'b1}};
      req_q     <= {NUM_CH{1'b0}};
      err_q     <= {NUM_CH{1'b0}};
      deas_q    <= {NUM_CH{1'b0}};
      req_any_q <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        dg_cnt_q[c]  <= {DG_W{1'b0}};
        frm_cnt_q[c] <= {FC_W{1'b0}};
        state_q[c]   <= ST_HIGH;
      end
    end else begin
      sync1_q   <= bus.i_sync_n;
      sync2_q   <= sync1_q;
      filt_q    <= filt_d;
      req_q     <= req_d;
      err_q     <= err_d;
      deas_q    <= deas_d;
      req_any_q <= req_any_d;
      for (int c = 0; c < NUM_CH; c++) begin
        dg_cnt_q[c]  <= dg_cnt_d[c];
        frm_cnt_q[c] <= frm_cnt_d[c];
        state_q[c]   <= state_d[c];
      end
    end
  end

  assign bus.o_sync_request  = req_q;
  assign bus.o_sync_req_any  = req_any_q;
  assign bus.o_err_report    = err_q;
  assign bus.o_sync_deassert = deas_q;

`ifdef SYNCN_ERR_CNT_EN
  logic [ERR_CNT_W-1:0]        ecnt_q [NUM_CH];
  logic [ERR_CNT_W-1:0]        ecnt_d [NUM_CH];
  logic [NUM_CH*ERR_CNT_W-1:0] ecnt_flat_s;

  // Counts follow the visible report pulse; clear beats a coincident increment.
  always_comb begin
    ecnt_flat_s = {(NUM_CH*ERR_CNT_W){1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.i_err_cnt_clr) begin
        ecnt_d[c] = {ERR_CNT_W{1'b0}};
      end else if (err_q[c] && (ecnt_q[c] != {ERR_CNT_W{1'b1}})) begin
        ecnt_d[c] = ecnt_q[c] + ERR_CNT_W'(1);
      end else begin
        ecnt_d[c] = ecnt_q[c];
      end
      ecnt_flat_s[c*ERR_CNT_W +: ERR_CNT_W] = ecnt_q[c];
    end
  end

  // Error counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        ecnt_q[c] <= {ERR_CNT_W{1'b0}};
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        ecnt_q[c] <= ecnt_d[c];
      end
    end
  end

  assign bus.o_err_cnt = ecnt_flat_s;
`endif

endmodule

// File: tb/tb_syncn_decoder_mch.sv
// Directed bench for syncn_decoder_mch: table of low-pulse lengths plus hand-written timing sequences.
// Error-counter checks run only when SYNCN_ERR_CNT_EN is defined.
module tb_syncn_decoder_mch;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  int   err_seen  [2];
  int   deas_seen [2];

  syncn_decoder_mch_if #(.NUM_CH(2), .ERR_CNT_W(8)) bus ();

  syncn_decoder_mch #(
    .NUM_CH(2), .SYNC_REQ_FRAMES(5), .ERR_MIN_FRAMES(1),
    .ERR_MAX_FRAMES(2), .DEGLITCH(2), .ERR_CNT_W(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (bus.o_err_report[c])    err_seen[c]  <= err_seen[c] + 1;
      if (bus.o_sync_deassert[c]) deas_seen[c] <= deas_seen[c] + 1;
    end
  end

  typedef struct {
    logic [1:0] mask;
    int         nt;
    logic [1:0] exp_req;
    logic [1:0] exp_err;
    logic [1:0] exp_deas;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    n_chk = n_chk + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic go_low(input logic [1:0] m);
    bus.i_sync_n = bus.i_sync_n & ~m;
    cyc(6);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      bus.i_frame_tick = 1'b1;
      cyc(1);
      bus.i_frame_tick = 1'b0;
      cyc(1);
    end
  endtask

  task automatic go_high(input logic [1:0] m);
    bus.i_sync_n = bus.i_sync_n | m;
    cyc(10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e1, d0, d1;
    n_chk  = 0;
    n_fail = 0;
    for (int c = 0; c < 2; c++) begin
      err_seen[c]  = 0;
      deas_seen[c] = 0;
    end
    vecs[0] = '{2'b01, 0, 2'b00, 2'b00, 2'b00};
    vecs[1] = '{2'b01, 1, 2'b00, 2'b01, 2'b00};
    vecs[2] = '{2'b01, 2, 2'b00, 2'b01, 2'b00};
    vecs[3] = '{2'b10, 3, 2'b00, 2'b00, 2'b00};
    vecs[4] = '{2'b10, 4, 2'b00, 2'b00, 2'b00};
    vecs[5] = '{2'b10, 5, 2'b10, 2'b00, 2'b10};
    vecs[6] = '{2'b11, 2, 2'b00, 2'b11, 2'b00};
    vecs[7] = '{2'b11, 6, 2'b11, 2'b00, 2'b11};

    rst_n            = 1'b0;
    bus.i_sync_n     = 2'b11;
    bus.i_frame_tick = 1'b0;
`ifdef SYNCN_ERR_CNT_EN
    bus.i_err_cnt_clr = 1'b0;
`endif
    cyc(2);
    chk("reset_req",     int'(bus.o_sync_request),  0);
    chk("reset_req_any", int'(bus.o_sync_req_any),  0);
    chk("reset_err",     int'(bus.o_err_report),    0);
    chk("reset_deas",    int'(bus.o_sync_deassert), 0);
    rst_n = 1'b1;
    cyc(4);

    for (int i = 0; i < 8; i++) begin
      e0 = err_seen[0]; e1 = err_seen[1]; d0 = deas_seen[0]; d1 = deas_seen[1];
      go_low(vecs[i].mask);
      ticks(vecs[i].nt);
      chk($sformatf("vec%0d_req", i),     int'(bus.o_sync_request), int'(vecs[i].exp_req));
      chk($sformatf("vec%0d_req_any", i), int'(bus.o_sync_req_any), int'(|vecs[i].exp_req));
      go_high(vecs[i].mask);
      chk($sformatf("vec%0d_err0", i),  err_seen[0] - e0,  int'(vecs[i].exp_err[0]));
      chk($sformatf("vec%0d_err1", i),  err_seen[1] - e1,  int'(vecs[i].exp_err[1]));
      chk($sformatf("vec%0d_deas0", i), deas_seen[0] - d0, int'(vecs[i].exp_deas[0]));
      chk($sformatf("vec%0d_deas1", i), deas_seen[1] - d1, int'(vecs[i].exp_deas[1]));
      chk($sformatf("vec%0d_req_after", i), int'(bus.o_sync_request), 0);
    end

    // Request latency after the 5th counted tick, and deassert timing.
    go_low(2'b01);
    for (int k = 1; k <= 5; k++) begin
      bus.i_frame_tick = 1'b1;
      cyc(1);
      chk($sformatf("t2_req_after_tick%0d", k), int'(bus.o_sync_request[0]), (k == 5) ? 1 : 0);
      bus.i_frame_tick = 1'b0;
      cyc(1);
    end
    chk("t2_req_any", int'(bus.o_sync_req_any), 1);
    chk("t2_ch1_req", int'(bus.o_sync_request[1]), 0);
    bus.i_sync_n[0] = 1'b1;
    cyc(4);
    chk("t2_req_edge3",  int'(bus.o_sync_request[0]),  1);
    chk("t2_deas_edge3", int'(bus.o_sync_deassert[0]), 0);
    cyc(1);
    chk("t2_req_edge4",     int'(bus.o_sync_request[0]), 0);
    chk("t2_deas_edge4",    int'(bus.o_sync_deassert),   1);
    chk("t2_req_any_edge4", int'(bus.o_sync_req_any),    0);
    cyc(1);
    chk("t2_deas_edge5", int'(bus.o_sync_deassert), 0);
    cyc(4);

    // Error report exactly 2+DEGLITCH edges after the rise.
    go_low(2'b10);
    ticks(2);
    bus.i_sync_n[1] = 1'b1;
    cyc(4);
    chk("t3_err_edge3", int'(bus.o_err_report), 0);
    cyc(1);
    chk("t3_err_edge4", int'(bus.o_err_report),   2);
    chk("t3_req",       int'(bus.o_sync_request), 0);
    cyc(1);
    chk("t3_err_edge5", int'(bus.o_err_report), 0);
    cyc(4);

    // Single-clock glitch must not disturb anything.
    e0 = err_seen[0]; d0 = deas_seen[0];
    bus.i_sync_n[0] = 1'b0;
    cyc(1);
    bus.i_sync_n[0] = 1'b1;
    ticks(3);
    cyc(8);
    chk("t4_glitch_err",  err_seen[0] - e0,  0);
    chk("t4_glitch_deas", deas_seen[0] - d0, 0);
    chk("t4_glitch_req",  int'(bus.o_sync_request), 0);

    // Simultaneous deassert on ch0 and error report on ch1.
    go_low(2'b01);
    ticks(5);
    go_low(2'b10);
    ticks(1);
    bus.i_sync_n = 2'b11;
    cyc(4);
    chk("t5_deas_edge3", int'(bus.o_sync_deassert), 0);
    cyc(1);
    chk("t5_deas", int'(bus.o_sync_deassert), 1);
    chk("t5_err",  int'(bus.o_err_report),    2);
    chk("t5_req",  int'(bus.o_sync_request),  0);
    cyc(1);
    chk("t5_pulses_end", int'(bus.o_sync_deassert | bus.o_err_report), 0);
    cyc(4);

    // Asynchronous reset in the middle of a request.
    go_low(2'b01);
    ticks(5);
    chk("t1_req_before", int'(bus.o_sync_request), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_req_async",     int'(bus.o_sync_request), 0);
    chk("t1_req_any_async", int'(bus.o_sync_req_any), 0);
    bus.i_sync_n = 2'b11;
    cyc(4);
    rst_n = 1'b1;
    e0 = err_seen[0]; e1 = err_seen[1]; d0 = deas_seen[0]; d1 = deas_seen[1];
    cyc(15);
    chk("t1_no_pulse_err",  (err_seen[0] - e0) + (err_seen[1] - e1), 0);
    chk("t1_no_pulse_deas", (deas_seen[0] - d0) + (deas_seen[1] - d1), 0);
    chk("t1_req_after",     int'(bus.o_sync_request), 0);

`ifdef SYNCN_ERR_CNT_EN
    bus.i_err_cnt_clr = 1'b1;
    cyc(1);
    bus.i_err_cnt_clr = 1'b0;
    cyc(1);
    chk("t6_cnt_cleared", int'(bus.o_err_cnt), 0);
    for (int k = 1; k <= 300; k++) begin
      go_low(2'b10);
      ticks(1);
      go_high(2'b10);
      if (k == 1) chk("t6_cnt_one", int'(bus.o_err_cnt[15:8]), 1);
    end
    chk("t6_cnt_sat", int'(bus.o_err_cnt[15:8]), 255);
    chk("t6_cnt_ch0", int'(bus.o_err_cnt[7:0]),  0);
    go_low(2'b10);
    ticks(1);
    bus.i_sync_n[1] = 1'b1;
    cyc(5);
    chk("t6_pulse_visible", int'(bus.o_err_report[1]), 1);
    bus.i_err_cnt_clr = 1'b1;
    cyc(1);
    bus.i_err_cnt_clr = 1'b0;
    chk("t6_clr_wins", int'(bus.o_err_cnt[15:8]), 0);
    cyc(2);
    chk("t6_clr_hold", int'(bus.o_err_cnt[15:8]), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
